// File: rtl/vga_timing_pkg.sv
// Shared timing constants, derived-total helper and sequencer state type
// for the VGA raster timing controller.
package vga_timing_pkg;

  // 640x480 @ 60 Hz industry timing
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CNT_W     = 10;

  // Full period of one axis (line length or frame height)
  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // Video sequencer: video starts and stops only on frame boundaries
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decode of the sync and
// visible windows for the value the counter is about to take, so the parent
// can register those flags on the same edge as the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             last_c,
  output logic             visible_nxt_c,
  output logic             sync_nxt_c
);

  localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC);

  assign last_c = (count == LAST);

  // Next position and window decode of that position
  always_comb begin
    count_nxt_c = count;
    if (advance) begin
      count_nxt_c = last_c ? '0 : count + CNT_W'(1);
    end
    visible_nxt_c = (count_nxt_c < VIS_END);
    sync_nxt_c    = (count_nxt_c >= SYNC_LO) && (count_nxt_c < SYNC_HI);
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: h/v counters, syncs, display enable and
// line/frame strobes, sequenced IDLE/RUN/DRAIN so video only starts and
// stops on frame boundaries.
// Optional build macro VGA_TIMING_LINE_IRQ_EN adds line_cmp/line_irq, a
// one-clock pulse when a new line equal to line_cmp begins.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             run,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0] line_cmp,
`endif
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
`ifdef VGA_TIMING_LINE_IRQ_EN
  output logic             line_irq,
`endif
  output logic             busy
);

  vga_state_e       state;
  logic             start_c;
  logic             counting_c;
  logic             h_adv_c;
  logic             v_adv_c;
  logic             drain_done_c;
  logic             active_nxt_c;
  logic [CNT_W-1:0] x_nxt_c;
  logic [CNT_W-1:0] y_nxt_c;
  logic             h_last_c;
  logic             v_last_c;
  logic             h_vis_nxt_c;
  logic             v_vis_nxt_c;
  logic             h_sync_nxt_c;
  logic             v_sync_nxt_c;

  // Horizontal axis advances on every enabled pixel while video is active
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .CNT_W(CNT_W)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (h_adv_c),
    .count        (pix_x),
    .count_nxt_c  (x_nxt_c),
    .last_c       (h_last_c),
    .visible_nxt_c(h_vis_nxt_c),
    .sync_nxt_c   (h_sync_nxt_c)
  );

  // Vertical axis advances only on the horizontal wrap
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .CNT_W(CNT_W)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (v_adv_c),
    .count        (pix_y),
    .count_nxt_c  (y_nxt_c),
    .last_c       (v_last_c),
    .visible_nxt_c(v_vis_nxt_c),
    .sync_nxt_c   (v_sync_nxt_c)
  );

  // Sequencer decode: counters sit at (0,0) in IDLE, so starting needs no load
  always_comb begin
    start_c      = (state == IDLE) && run && pix_en;
    counting_c   = (state != IDLE);
    h_adv_c      = counting_c && pix_en;
    v_adv_c      = h_adv_c && h_last_c;
    drain_done_c = (state == DRAIN) && !run && v_adv_c && v_last_c;
    active_nxt_c = start_c || (counting_c && !drain_done_c);
  end

  // Sequencer state and all registered outputs, aligned with the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
      line_irq    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (start_c) state <= RUN;
        RUN:     if (!run) state <= DRAIN;
        DRAIN: begin
          if (run) begin
            state <= RUN;
          end else if (drain_done_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      busy        <= active_nxt_c;
      de          <= active_nxt_c && h_vis_nxt_c && v_vis_nxt_c;
      hsync       <= (active_nxt_c && h_sync_nxt_c) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (active_nxt_c && v_sync_nxt_c) ? SYNC_POL : ~SYNC_POL;
      line_start  <= active_nxt_c && pix_en && (x_nxt_c == '0);
      frame_start <= active_nxt_c && pix_en && (x_nxt_c == '0) && (y_nxt_c == '0);
`ifdef VGA_TIMING_LINE_IRQ_EN
      line_irq    <= active_nxt_c && v_adv_c && (y_nxt_c == line_cmp);
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a reduced raster (32x21) so whole frames
// fit in a short run; a linear-position model is compared every cycle.
module tb_vga_timing_ctrl;

  localparam int unsigned HV = 20, HF = 4, HS = 6, HB = 2;
  localparam int unsigned VV = 12, VF = 2, VS = 3, VB = 4;
  localparam int HT    = 32;
  localparam int VT    = 21;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       run;
  logic       hsync, vsync, de, line_start, frame_start, busy;
  logic [9:0] pix_x, pix_y;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [9:0] line_cmp;
  logic       line_irq;
`endif

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  half   = 1'b0;
  bit  chk_en = 1'b0;

  vga_timing_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .run        (run),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp   (line_cmp),
`endif
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .line_start (line_start),
    .frame_start(frame_start),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_irq   (line_irq),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model: mode 0 idle, 1 run, 2 drain; position is a linear pixel index
  int m_mode = 0;
  int m_p    = 0;
  bit m_ls = 0, m_fs = 0, m_irq = 0;
  bit m_tick, m_was_last, m_wrap;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_p = 0; m_ls = 0; m_fs = 0; m_irq = 0;
    end else begin
      m_ls = 0; m_fs = 0; m_irq = 0;
      if (m_mode == 0) begin
        if (run && pix_en) begin
          m_mode = 1; m_p = 0; m_ls = 1; m_fs = 1;
        end
      end else begin
        m_tick     = pix_en;
        m_was_last = (m_p == FRAME - 1);
        m_wrap     = m_tick && (m_p % HT == HT - 1);
        if (m_tick) m_p = (m_p + 1) % FRAME;
        if (m_mode == 1) begin
          if (!run) m_mode = 2;
        end else if (run) begin
          m_mode = 1;
        end else if (m_tick && m_was_last) begin
          m_mode = 0;
        end
        if (m_mode != 0) begin
          m_ls = m_wrap;
          m_fs = m_tick && m_was_last;
`ifdef VGA_TIMING_LINE_IRQ_EN
          m_irq = m_wrap && ((m_p / HT) == int'(line_cmp));
`endif
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  int e_x, e_y;
  bit e_act;
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      e_act = (m_mode != 0);
      e_x   = m_p % HT;
      e_y   = m_p / HT;
      chk("pix_x", int'(pix_x), e_x);
      chk("pix_y", int'(pix_y), e_y);
      chk("busy", int'(busy), int'(e_act));
      chk("de", int'(de), int'(e_act && e_x < HV && e_y < VV));
      chk("hsync", int'(hsync), int'(!(e_act && e_x >= HV + HF && e_x < HV + HF + HS)));
      chk("vsync", int'(vsync), int'(!(e_act && e_y >= VV + VF && e_y < VV + VF + VS)));
      chk("line_start", int'(line_start), int'(m_ls));
      chk("frame_start", int'(frame_start), int'(m_fs));
`ifdef VGA_TIMING_LINE_IRQ_EN
      chk("line_irq", int'(line_irq), int'(m_irq));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    if (half) pix_en = ~pix_en;
  endtask

  task automatic wait_fs(input int bound);
    int n = 0;
    while (!frame_start && n < bound) begin step(); n++; end
    chk("wait_frame_start", int'(frame_start), 1);
  endtask

  task automatic wait_xy(input int x, input int y, input int bound);
    int n = 0;
    while (!(int'(pix_x) == x && int'(pix_y) == y) && n < bound) begin step(); n++; end
    chk("wait_xy_x", int'(pix_x), x);
    chk("wait_xy_y", int'(pix_y), y);
  endtask

  // Called on a frame_start cycle; measures one frame against literal values
  task automatic measure_frame(input int mul, input int exp_irq);
    int cyc = 0, n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0;
    int hs_x = -1, vs_x = -1, vs_y = -1;
    int n_irq = 0, irq_x = -1, irq_y = -1;
    do begin
      if (de) n_de++;
      if (!hsync) begin n_hs++; if (hs_x < 0) hs_x = int'(pix_x); end
      if (!vsync) begin
        n_vs++;
        if (vs_y < 0) begin vs_x = int'(pix_x); vs_y = int'(pix_y); end
      end
      if (line_start) n_ls++;
`ifdef VGA_TIMING_LINE_IRQ_EN
      if (line_irq) begin n_irq++; irq_x = int'(pix_x); irq_y = int'(pix_y); end
`endif
      step();
      cyc++;
    end while (!frame_start && cyc < 4000);
    chk("frame_period", cyc, 672 * mul);
    chk("de_cycles", n_de, 240 * mul);
    chk("hsync_low_cycles", n_hs, 126 * mul);
    chk("vsync_low_cycles", n_vs, 96 * mul);
    chk("line_starts", n_ls, 21);
    chk("hsync_first_x", hs_x, 24);
    chk("vsync_first_x", vs_x, 0);
    chk("vsync_first_y", vs_y, 14);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("line_irq_count", n_irq, exp_irq);
    chk("line_irq_x", irq_x, exp_irq ? 0 : -1);
    chk("line_irq_y", irq_y, exp_irq ? 11 : -1);
`else
    n_irq = exp_irq; irq_x = n_irq; irq_y = irq_x;
`endif
  endtask

  initial begin
    int t, nfs, px, py;
    rst_n = 1'b0; run = 1'b0; pix_en = 1'b1;
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_cmp = 10'd11;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(); step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_frame_start", int'(frame_start), 0);

    // Start: strobes and first visible pixel on the first tick
    run = 1'b1;
    step();
    chk("start_frame_start", int'(frame_start), 1);
    chk("start_line_start", int'(line_start), 1);
    chk("start_de", int'(de), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_pix_x", int'(pix_x), 0);
    chk("start_pix_y", int'(pix_y), 0);
    measure_frame(1, 1);

    // Half-rate pixel enable doubles every timing
    half = 1'b1;
    step();
    wait_fs(3000);
    measure_frame(2, 1);
    half = 1'b0;
    pix_en = 1'b1;

    // Stop and return to idle
    run = 1'b0;
    t = 0;
    while (busy && t < 3000) begin step(); t++; end
    chk("stop_idle_busy", int'(busy), 0);

    // Drop run at line 5: drain to end of frame, no new frame
    run = 1'b1;
    step();
    chk("restart_frame_start", int'(frame_start), 1);
    t = 0; nfs = 0; px = -1; py = -1;
    while (busy && t < 2000) begin
      px = int'(pix_x); py = int'(pix_y);
      step(); t++;
      if (t == 160) run = 1'b0;
      if (frame_start) nfs++;
    end
    chk("drain_cycles", t, 672);
    chk("drain_frame_starts", nfs, 0);
    chk("drain_last_x", px, 31);
    chk("drain_last_y", py, 20);
    chk("drain_idle_x", int'(pix_x), 0);
    chk("drain_idle_y", int'(pix_y), 0);
    chk("drain_idle_hsync", int'(hsync), 1);
    chk("drain_idle_vsync", int'(vsync), 1);
    chk("drain_idle_de", int'(de), 0);

    // Drop and re-raise run within the frame: counting is continuous
    run = 1'b1;
    step();
    t = 0;
    do begin
      step(); t++;
      if (t == 100) run = 1'b0;
      if (t == 105) run = 1'b1;
    end while (!frame_start && t < 2000);
    chk("rerun_frame_period", t, 672);
    chk("rerun_busy", int'(busy), 1);

`ifdef VGA_TIMING_LINE_IRQ_EN
    // Compare value beyond the frame height never fires
    line_cmp = 10'd30;
    measure_frame(1, 0);
    line_cmp = 10'd11;
`endif

    // Asynchronous reset mid-frame, between clock edges
    wait_xy(10, 5, 1000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pix_x", int'(pix_x), 0);
    chk("arst_pix_y", int'(pix_y), 0);
    chk("arst_hsync", int'(hsync), 1);
    chk("arst_vsync", int'(vsync), 1);
    chk("arst_de", int'(de), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("arst_hold_x", int'(pix_x), 0);
    chk("arst_hold_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
